// File: rtl/ro_cache_mem_ctrl_mb.sv
// Banked multi-port data array for the read-only cache, one-cycle reads.
// RO_CACHE_MEM_CTRL_AGING_EN adds per-requester aging to prevent starvation.
module ro_cache_mem_ctrl_mb #(
   parameter int MEM_DEPTH  = 64,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_RD     = 4,
   parameter int NUM_BANKS  = 2,
   parameter int AGE_LIMIT  = 7,
   localparam int AW = $clog2(MEM_DEPTH)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_RD*AW-1:0]         rd_addr,
   input  logic [NUM_RD-1:0]            rd_en,
   input  logic [NUM_RD*2-1:0]          rd_pri,
   output logic [NUM_RD-1:0]            rd_ready,
   output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
   output logic [NUM_RD-1:0]            rd_valid,
   input  logic [AW-1:0]                fetch_raddr,
   input  logic                         fetch_ren,
   output logic                         fetch_rready,
   output logic [DATA_WIDTH-1:0]        fetch_rdata,
   output logic                         fetch_rvalid,
   input  logic [AW-1:0]                fetch_waddr,
   input  logic                         fetch_wen,
   input  logic [DATA_WIDTH-1:0]        fetch_wdata,
   output logic                         fetch_wready
);

   localparam int NR   = NUM_RD + 1;
   localparam int IW   = $clog2(NR);
   localparam int LB   = $clog2(NUM_BANKS);
   localparam int BW   = (LB > 0) ? LB : 1;
   localparam int RW   = AW - LB;
   localparam int ROWS = MEM_DEPTH / NUM_BANKS;
   localparam int DW   = DATA_WIDTH;

   if (NUM_RD < 1 || NUM_RD > 8 || NUM_BANKS < 1 || NUM_BANKS > 8 ||
       AGE_LIMIT < 1 || (MEM_DEPTH % NUM_BANKS) != 0) begin : g_param_err
      $error("ro_cache_mem_ctrl_mb: illegal parameter set");
   end

   function automatic logic [BW-1:0] bank_of(input logic [AW-1:0] a);
      logic [AW-1:0] m;
      m = a & AW'(NUM_BANKS - 1);
      return m[BW-1:0];
   endfunction

   function automatic logic [RW-1:0] row_of(input logic [AW-1:0] a);
      logic [AW-1:0] s;
      s = a >> LB;
      return s[RW-1:0];
   endfunction

   logic [DW-1:0] mem_q   [NUM_BANKS][ROWS];
   logic [IW-1:0] ptr_q   [NUM_BANKS];
   logic [IW-1:0] ptr_d   [NUM_BANKS];
   logic [IW-1:0] win     [NUM_BANKS];
   logic          win_vld [NUM_BANKS];
   logic [NR-1:0] grant;
   logic [NR-1:0] vld_q;
   logic [DW-1:0] data_q  [NR];
   logic [DW-1:0] rdata   [NR];

   logic [AW-1:0] req_addr [NR];
   logic          req_en   [NR];
   logic [2:0]    req_pri  [NR];
   logic [BW-1:0] req_bank [NR];
   logic [RW-1:0] req_row  [NR];

`ifdef RO_CACHE_MEM_CTRL_AGING_EN
   localparam int AGW = $clog2(AGE_LIMIT + 1);
   localparam logic [AGW-1:0] AGE_MAX = AGW'(AGE_LIMIT);

   logic [AGW-1:0] age_q [NR];
   logic [AGW-1:0] age_d [NR];
`endif

   // Requester NUM_RD is the refill read port at fixed priority 3.
   always_comb begin
      for (int i = 0; i < NUM_RD; i++) begin
         req_addr[i] = rd_addr[i*AW +: AW];
         req_en[i]   = rd_en[i] & rst_n;
         req_pri[i]  = {1'b0, rd_pri[i*2 +: 2]};
      end
      req_addr[NUM_RD] = fetch_raddr;
      req_en[NUM_RD]   = fetch_ren & rst_n;
      req_pri[NUM_RD]  = 3'd3;
`ifdef RO_CACHE_MEM_CTRL_AGING_EN
      for (int i = 0; i < NR; i++) begin
         if (age_q[i] == AGE_MAX) req_pri[i] = 3'd4;
      end
`endif
      for (int i = 0; i < NR; i++) begin
         req_bank[i] = bank_of(req_addr[i]);
         req_row[i]  = row_of(req_addr[i]);
      end
   end

   // Scan from the RR pointer; strict '>' keeps the earliest tie winner.
   always_comb begin : arb
      logic [2:0]    best;
      logic [IW:0]   sum;
      logic [IW-1:0] idx;
      best  = '0;
      sum   = '0;
      idx   = '0;
      grant = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         win[b]     = '0;
         win_vld[b] = 1'b0;
         best       = '0;
         for (int k = 0; k < NR; k++) begin
            sum = {1'b0, ptr_q[b]} + (IW+1)'(k);
            if (sum >= (IW+1)'(NR)) sum = sum - (IW+1)'(NR);
            idx = sum[IW-1:0];
            if (req_en[idx] && req_bank[idx] == BW'(b) &&
                (!win_vld[b] || req_pri[idx] > best)) begin
               win_vld[b] = 1'b1;
               win[b]     = idx;
               best       = req_pri[idx];
            end
         end
         ptr_d[b] = ptr_q[b];
         if (win_vld[b]) begin
            grant[win[b]] = 1'b1;
            ptr_d[b] = (win[b] == IW'(NR - 1)) ? '0 : win[b] + 1'b1;
         end
      end
   end

   // Same-cycle fill to the read address wins over the array.
   always_comb begin
      for (int i = 0; i < NR; i++) begin
         if (fetch_wen && fetch_waddr == req_addr[i])
            rdata[i] = fetch_wdata;
         else
            rdata[i] = mem_q[req_bank[i]][req_row[i]];
      end
   end

`ifdef RO_CACHE_MEM_CTRL_AGING_EN
   always_comb begin
      for (int i = 0; i < NR; i++) begin
         if (!req_en[i] || grant[i])
            age_d[i] = '0;
         else if (age_q[i] != AGE_MAX)
            age_d[i] = age_q[i] + 1'b1;
         else
            age_d[i] = age_q[i];
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < NUM_BANKS; b++) ptr_q[b] <= '0;
         for (int i = 0; i < NR; i++) data_q[i] <= '0;
         vld_q <= '0;
`ifdef RO_CACHE_MEM_CTRL_AGING_EN
         for (int i = 0; i < NR; i++) age_q[i] <= '0;
`endif
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) ptr_q[b] <= ptr_d[b];
         for (int i = 0; i < NR; i++) begin
            if (grant[i]) data_q[i] <= rdata[i];
         end
         vld_q <= grant;
`ifdef RO_CACHE_MEM_CTRL_AGING_EN
         for (int i = 0; i < NR; i++) age_q[i] <= age_d[i];
`endif
         if (fetch_wen)
            mem_q[bank_of(fetch_waddr)][row_of(fetch_waddr)] <= fetch_wdata;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_RD; i++) rd_data[i*DW +: DW] = data_q[i];
   end

   assign rd_ready     = grant[NUM_RD-1:0];
   assign rd_valid     = vld_q[NUM_RD-1:0];
   assign fetch_rready = grant[NUM_RD];
   assign fetch_rvalid = vld_q[NUM_RD];
   assign fetch_rdata  = data_q[NUM_RD];
   assign fetch_wready = 1'b1;

endmodule

// File: tb/tb_ro_cache_mem_ctrl_mb.sv
// Directed bench for ro_cache_mem_ctrl_mb (default parameters).
// Aging expectations follow RO_CACHE_MEM_CTRL_AGING_EN.
module tb_ro_cache_mem_ctrl_mb;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [23:0]  rd_addr;
   logic [3:0]   rd_en;
   logic [7:0]   rd_pri;
   logic [3:0]   rd_ready;
   logic [127:0] rd_data;
   logic [3:0]   rd_valid;
   logic [5:0]   fetch_raddr;
   logic         fetch_ren;
   logic         fetch_rready;
   logic [31:0]  fetch_rdata;
   logic         fetch_rvalid;
   logic [5:0]   fetch_waddr;
   logic         fetch_wen;
   logic [31:0]  fetch_wdata;
   logic         fetch_wready;

   int checks = 0;
   int errors = 0;

   ro_cache_mem_ctrl_mb dut (
      .clk(clk), .rst_n(rst_n),
      .rd_addr(rd_addr), .rd_en(rd_en), .rd_pri(rd_pri),
      .rd_ready(rd_ready), .rd_data(rd_data), .rd_valid(rd_valid),
      .fetch_raddr(fetch_raddr), .fetch_ren(fetch_ren),
      .fetch_rready(fetch_rready), .fetch_rdata(fetch_rdata),
      .fetch_rvalid(fetch_rvalid),
      .fetch_waddr(fetch_waddr), .fetch_wen(fetch_wen),
      .fetch_wdata(fetch_wdata), .fetch_wready(fetch_wready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]       en;
      logic [7:0]       pri;
      logic [23:0]      ad;
      logic             fren;
      logic [5:0]       fra;
      logic             fwen;
      logic [5:0]       fwa;
      logic [31:0]      fwd;
      logic [4:0]       rdy;
      logic [4:0]       vld;
      logic [4:0]       dm;
      logic [4:0][31:0] d;
   } vec_t;

   vec_t vq[$];

   function automatic logic [23:0] a4(int a0, int a1, int a2, int a3);
      return {a3[5:0], a2[5:0], a1[5:0], a0[5:0]};
   endfunction

   function automatic logic [7:0] p4(int p0, int p1, int p2, int p3);
      return {p3[1:0], p2[1:0], p1[1:0], p0[1:0]};
   endfunction

   function automatic logic [4:0][31:0] d5(logic [31:0] d0, logic [31:0] d1,
                                          logic [31:0] d2, logic [31:0] d3,
                                          logic [31:0] d4);
      logic [4:0][31:0] r;
      r[0] = d0; r[1] = d1; r[2] = d2; r[3] = d3; r[4] = d4;
      return r;
   endfunction

   function automatic vec_t mk(logic [3:0] en, logic [7:0] pri,
                               logic [23:0] ad, logic fren, logic [5:0] fra,
                               logic fwen, logic [5:0] fwa, logic [31:0] fwd,
                               logic [4:0] rdy, logic [4:0] vld,
                               logic [4:0] dm, logic [4:0][31:0] d);
      vec_t v;
      v.en = en; v.pri = pri; v.ad = ad;
      v.fren = fren; v.fra = fra;
      v.fwen = fwen; v.fwa = fwa; v.fwd = fwd;
      v.rdy = rdy; v.vld = vld; v.dm = dm; v.d = d;
      return v;
   endfunction

   function automatic vec_t wr(logic [5:0] a, logic [31:0] d);
      return mk(4'b0, 8'b0, 24'b0, 1'b0, 6'd0, 1'b1, a, d,
                5'b0, 5'b0, 5'b0, '0);
   endfunction

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(vec_t v);
      rd_en       = v.en;
      rd_pri      = v.pri;
      rd_addr     = v.ad;
      fetch_ren   = v.fren;
      fetch_raddr = v.fra;
      fetch_wen   = v.fwen;
      fetch_waddr = v.fwa;
      fetch_wdata = v.fwd;
   endtask

   vec_t idle;
   vec_t v;
   logic [3:0] exp_rdy;

   initial begin
      idle = mk(4'b0, 8'b0, 24'b0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0,
                5'b0, 5'b0, 5'b0, '0);
      // preload through the fill port
      vq.push_back(wr(6'd5, 32'h0000A5A5));
      vq.push_back(wr(6'd4, 32'h00000044));
      vq.push_back(wr(6'd7, 32'h00000077));
      vq.push_back(wr(6'd2, 32'h00000022));
      vq.push_back(wr(6'd6, 32'h00000066));
      vq.push_back(wr(6'd9, 32'h00000099));
      // single port read, pulse then hold
      vq.push_back(mk(4'b0001, p4(0,0,0,0), a4(5,0,0,0), 1'b0, 6'd0, 1'b0, 6'd0, 32'd0,
                      5'b00001, 5'b00000, 5'b00000, '0));
      vq.push_back(mk(4'b0000, 8'b0, 24'b0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0,
                      5'b00000, 5'b00001, 5'b00001, d5(32'hA5A5, 0, 0, 0, 0)));
      vq.push_back(mk(4'b0000, 8'b0, 24'b0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0,
                      5'b00000, 5'b00000, 5'b00001, d5(32'hA5A5, 0, 0, 0, 0)));
      // two banks in parallel
      vq.push_back(mk(4'b0011, p4(1,1,0,0), a4(4,7,0,0), 1'b0, 6'd0, 1'b0, 6'd0, 32'd0,
                      5'b00011, 5'b00000, 5'b00000, '0));
      vq.push_back(mk(4'b0000, 8'b0, 24'b0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0,
                      5'b00000, 5'b00011, 5'b00011, d5(32'h44, 32'h77, 0, 0, 0)));
      // priority with round robin among the two pri-3 ports
      vq.push_back(mk(4'b1111, p4(1,3,3,0), a4(2,2,2,2), 1'b0, 6'd0, 1'b0, 6'd0, 32'd0,
                      5'b00010, 5'b00000, 5'b00000, '0));
      vq.push_back(mk(4'b1111, p4(1,3,3,0), a4(2,2,2,2), 1'b0, 6'd0, 1'b0, 6'd0, 32'd0,
                      5'b00100, 5'b00010, 5'b00010, d5(0, 32'h22, 0, 0, 0)));
      vq.push_back(mk(4'b1111, p4(1,3,3,0), a4(2,2,2,2), 1'b0, 6'd0, 1'b0, 6'd0, 32'd0,
                      5'b00010, 5'b00100, 5'b00100, d5(0, 0, 32'h22, 0, 0)));
      vq.push_back(mk(4'b1111, p4(1,3,3,0), a4(2,2,2,2), 1'b0, 6'd0, 1'b0, 6'd0, 32'd0,
                      5'b00100, 5'b00010, 5'b00010, d5(0, 32'h22, 0, 0, 0)));
      vq.push_back(mk(4'b0000, 8'b0, 24'b0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0,
                      5'b00000, 5'b00100, 5'b00100, d5(0, 0, 32'h22, 0, 0)));
      // write-first bypass, then different-address write
      vq.push_back(mk(4'b0100, p4(0,0,0,0), a4(0,0,9,0), 1'b0, 6'd0, 1'b1, 6'd9, 32'h1234,
                      5'b00100, 5'b00000, 5'b00000, '0));
      vq.push_back(mk(4'b0100, p4(0,0,0,0), a4(0,0,9,0), 1'b0, 6'd0, 1'b0, 6'd0, 32'd0,
                      5'b00100, 5'b00100, 5'b00100, d5(0, 0, 32'h1234, 0, 0)));
      vq.push_back(mk(4'b0100, p4(0,0,0,0), a4(0,0,9,0), 1'b0, 6'd0, 1'b1, 6'd11, 32'hBB,
                      5'b00100, 5'b00100, 5'b00100, d5(0, 0, 32'h1234, 0, 0)));
      vq.push_back(mk(4'b0100, p4(0,0,0,0), a4(0,0,11,0), 1'b0, 6'd0, 1'b0, 6'd0, 32'd0,
                      5'b00100, 5'b00100, 5'b00100, d5(0, 0, 32'h1234, 0, 0)));
      vq.push_back(mk(4'b0000, 8'b0, 24'b0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0,
                      5'b00000, 5'b00100, 5'b00100, d5(0, 0, 32'hBB, 0, 0)));
      // fetch read beats a pri-2 lookup on the same bank
      vq.push_back(mk(4'b0001, p4(2,0,0,0), a4(6,0,0,0), 1'b1, 6'd6, 1'b0, 6'd0, 32'd0,
                      5'b10000, 5'b00000, 5'b00000, '0));
      vq.push_back(mk(4'b0001, p4(2,0,0,0), a4(6,0,0,0), 1'b0, 6'd0, 1'b0, 6'd0, 32'd0,
                      5'b00001, 5'b10000, 5'b10000, d5(0, 0, 0, 0, 32'h66)));
      vq.push_back(mk(4'b0000, 8'b0, 24'b0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0,
                      5'b00000, 5'b00001, 5'b10001, d5(32'h66, 0, 0, 0, 32'h66)));

      rst_n = 1'b0;
      drive(idle);
      repeat (2) @(negedge clk);
      check("rst_ready", {27'b0, fetch_rready, rd_ready}, 32'd0);
      check("rst_valid", {27'b0, fetch_rvalid, rd_valid}, 32'd0);
      check("rst_data0", rd_data[31:0], 32'd0);
      check("rst_data3", rd_data[127:96], 32'd0);
      check("rst_fdata", fetch_rdata, 32'd0);
      check("wready", {31'b0, fetch_wready}, 32'd1);
      rst_n = 1'b1;

      foreach (vq[k]) begin
         @(posedge clk); #1;
         drive(vq[k]);
         @(negedge clk);
         check($sformatf("v%0d_ready", k), {27'b0, fetch_rready, rd_ready},
               {27'b0, vq[k].rdy});
         check($sformatf("v%0d_valid", k), {27'b0, fetch_rvalid, rd_valid},
               {27'b0, vq[k].vld});
         for (int p = 0; p < 5; p++) begin
            if (vq[k].dm[p])
               check($sformatf("v%0d_data%0d", k, p),
                     (p == 4) ? fetch_rdata : rd_data[p*32 +: 32], vq[k].d[p]);
         end
      end

      // pri-0 port3 against pri-3 port1 on one bank
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         v = idle;
         v.en = 4'b1010; v.pri = p4(0,3,0,0); v.ad = a4(0,2,0,2);
         drive(v);
         @(negedge clk);
`ifdef RO_CACHE_MEM_CTRL_AGING_EN
         exp_rdy = (i == 7 || i == 15) ? 4'b1000 : 4'b0010;
`else
         exp_rdy = 4'b0010;
`endif
         check($sformatf("age%0d_ready", i), {28'b0, rd_ready}, {28'b0, exp_rdy});
      end

      // async reset drops an in-flight read and blocks writes
      @(posedge clk); #1;
      v = idle;
      v.en = 4'b0001; v.ad = a4(5,0,0,0);
      drive(v);
      @(negedge clk);
      check("pre_rst_ready", {28'b0, rd_ready}, 32'd1);
      #2 rst_n = 1'b0;
      v.fwen = 1'b1; v.fwa = 6'd5; v.fwd = 32'hDEAD;
      drive(v);
      #1;
      check("in_rst_ready", {28'b0, rd_ready}, 32'd0);
      @(posedge clk); #1;
      check("in_rst_valid", {28'b0, rd_valid}, 32'd0);
      check("in_rst_data0", rd_data[31:0], 32'd0);
      @(negedge clk);
      drive(idle);
      rst_n = 1'b1;
      @(posedge clk); #1;
      v = idle;
      v.en = 4'b0001; v.ad = a4(5,0,0,0);
      drive(v);
      @(negedge clk);
      check("post_rst_ready", {28'b0, rd_ready}, 32'd1);
      @(posedge clk); #1;
      drive(idle);
      @(negedge clk);
      check("post_rst_valid", {28'b0, rd_valid}, 32'd1);
      check("post_rst_data0", rd_data[31:0], 32'hA5A5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
